// File: rtl/fwrisc_mem_arbiter.sv
// rtl/fwrisc_mem_arbiter.sv - shares one memory port between the fwrisc fetch and data ports
//
// Purpose:
//   Arbitrates between the instruction-fetch requester (i*) and the data requester (d*),
//   registers the granted request onto the shared memory port (m*), holds it until
//   mready or a watchdog timeout, then returns a one-cycle ready pulse to the owner.
//
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   iaddr, ivalid                fetch request (held until iready)
//   iready, idata                fetch completion pulse and read data
//   daddr, dwdata, dstrb, dwrite data request payload
//   dvalid                       data request (held until dready)
//   dready, drdata               data completion pulse and load data
//   maddr, mwdata, mstrb, mwrite registered shared-port request payload
//   mvalid, mready, mrdata       shared-port handshake and read data
//   err                          pulses alongside the ready of a timed-out transaction
module fwrisc_mem_arbiter #(
  parameter int D_PRIORITY = 1,
  parameter int TIMEOUT    = 0,
  parameter int TMO_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic        iready,
  output logic [31:0] idata,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready,
  output logic [31:0] drdata,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mstrb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic        mready,
  input  logic [31:0] mrdata,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
  localparam logic             D_PRI    = (D_PRIORITY != 0);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;     // 1: data port owns the transaction
  logic              last_d_q, last_d_d;   // 1: data port was granted last
  logic [31:0]       maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [3:0]        mstrb_q, mstrb_d;
  logic              mwrite_q, mwrite_d;
  logic              mvalid_q, mvalid_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;
  logic              err_q, err_d;
  logic [31:0]       idata_q, idata_d;
  logic [31:0]       drdata_q, drdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              pick_d;
  logic              tmo_hit;
  logic [31:0]       resp_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d_d  = last_d_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mstrb_d   = mstrb_q;
    mwrite_d  = mwrite_q;
    mvalid_d  = mvalid_q;
    idata_d   = idata_q;
    drdata_d  = drdata_q;
    tmo_d     = tmo_q;
    // Ready and err are only ever high in RESP, which always lasts one cycle.
    iready_d  = 1'b0;
    dready_d  = 1'b0;
    err_d     = 1'b0;

    // Data wins a tie under fixed priority, or under round-robin when fetch went last.
    pick_d    = dvalid && (!ivalid || D_PRI || !last_d_q);
    tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);
    resp_data = mready ? mrdata : 32'hFFFF_FFFF;

    case (state_q)
      ST_IDLE: begin
        if (ivalid || dvalid) begin
          owner_d  = pick_d;
          last_d_d = pick_d;
          maddr_d  = pick_d ? daddr : iaddr;
          mwdata_d = pick_d ? dwdata : 32'h0;
          mstrb_d  = pick_d ? dstrb : 4'hf;
          mwrite_d = pick_d && dwrite;
          mvalid_d = 1'b1;
          tmo_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mready || tmo_hit) begin
          mvalid_d = 1'b0;
          err_d    = !mready;
          if (owner_q) begin
            dready_d = 1'b1;
            drdata_d = resp_data;
          end else begin
            iready_d = 1'b1;
            idata_d  = resp_data;
          end
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_d_q <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      mstrb_q  <= 4'h0;
      mwrite_q <= 1'b0;
      mvalid_q <= 1'b0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
      idata_q  <= 32'h0;
      drdata_q <= 32'h0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mstrb_q  <= mstrb_d;
      mwrite_q <= mwrite_d;
      mvalid_q <= mvalid_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      err_q    <= err_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      tmo_q    <= tmo_d;
    end
  end

  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign mstrb  = mstrb_q;
  assign mwrite = mwrite_q;
  assign mvalid = mvalid_q;
  assign iready = iready_q;
  assign dready = dready_q;
  assign err    = err_q;
  assign idata  = idata_q;
  assign drdata = drdata_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb/tb_fwrisc_mem_arbiter.sv - self-checking bench for fwrisc_mem_arbiter
module tb_fwrisc_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dwrite;
  logic        dvalid;
  logic        mready;
  logic [31:0] mrdata;

  // Instance A: data priority, 4-cycle watchdog
  logic        a_iready, a_dready, a_mwrite, a_mvalid, a_err;
  logic [31:0] a_idata, a_drdata, a_maddr, a_mwdata;
  logic [3:0]  a_mstrb;
  // Instance B: round-robin, watchdog disabled
  logic        b_iready, b_dready, b_mwrite, b_mvalid, b_err;
  logic [31:0] b_idata, b_drdata, b_maddr, b_mwdata;
  logic [3:0]  b_mstrb;

  fwrisc_mem_arbiter #(.D_PRIORITY(1), .TIMEOUT(4), .TMO_W(8)) dut_a (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .iready(a_iready), .idata(a_idata),
    .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid),
    .dready(a_dready), .drdata(a_drdata),
    .maddr(a_maddr), .mwdata(a_mwdata), .mstrb(a_mstrb), .mwrite(a_mwrite),
    .mvalid(a_mvalid), .mready(mready), .mrdata(mrdata), .err(a_err)
  );

  fwrisc_mem_arbiter #(.D_PRIORITY(0), .TIMEOUT(0), .TMO_W(8)) dut_b (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .iready(b_iready), .idata(b_idata),
    .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid),
    .dready(b_dready), .drdata(b_drdata),
    .maddr(b_maddr), .mwdata(b_mwdata), .mstrb(b_mstrb), .mwrite(b_mwrite),
    .mvalid(b_mvalid), .mready(mready), .mrdata(mrdata), .err(b_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic        dw;
    logic [31:0] dwd;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] mrd;
    logic        chk_m;
    logic        e_mvalid;
    logic        e_iready;
    logic        e_dready;
    logic        e_err;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [3:0]  e_mstrb;
    logic        e_mwrite;
    logic [31:0] e_idata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ivalid = 1'b0; iaddr = 32'h0;
    dvalid = 1'b0; daddr = 32'h0; dwdata = 32'h0; dstrb = 4'h0; dwrite = 1'b0;
    mready = 1'b0; mrdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Test vectors: inputs applied, one clock, outputs of instance A compared.
    //             iv    ia            dv    da            dw    dwd           ds     mr    mrd           chk   mv    ir    dr    err   maddr         mwdata        mstrb  mwr   idata         drdata
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,      32'h0,        4'hf, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,      32'h0,        4'hf, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 32'h13,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h13,       32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h13,       32'h0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'h2002,     1'b1, 32'hAABB,     4'hC, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2002,     32'hAABB,     4'hC, 1'b1, 32'h13,       32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 32'h2002,     1'b1, 32'hAABB,     4'hC, 1'b1, 32'h5555,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h13,       32'h5555};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h13,       32'h5555};
    vecs[8]  = '{1'b1, 32'h104,      1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104,      32'h0,        4'hf, 1'b0, 32'h13,       32'h5555};
    vecs[9]  = '{1'b0, 32'h500,      1'b1, 32'h999,      1'b1, 32'h1,        4'h1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104,      32'h0,        4'hf, 1'b0, 32'h13,       32'h5555};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 32'h2A,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h2A,       32'h5555};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h2A,       32'h5555};

    do_reset();

    // Reset state
    check1("rst mvalid", a_mvalid, 1'b0);
    check1("rst iready", a_iready, 1'b0);
    check1("rst dready", a_dready, 1'b0);
    check1("rst err", a_err, 1'b0);
    check1("rst mwrite", a_mwrite, 1'b0);
    check("rst maddr", a_maddr, 32'h0);
    check("rst mwdata", a_mwdata, 32'h0);
    check("rst mstrb", {28'h0, a_mstrb}, 32'h0);
    check("rst idata", a_idata, 32'h0);
    check("rst drdata", a_drdata, 32'h0);

    // Fetch, store, stray mready, early valid drop
    for (int i = 0; i < 12; i++) begin
      ivalid = vecs[i].iv;  iaddr  = vecs[i].ia;
      dvalid = vecs[i].dv;  daddr  = vecs[i].da;  dwrite = vecs[i].dw;
      dwdata = vecs[i].dwd; dstrb  = vecs[i].ds;
      mready = vecs[i].mr;  mrdata = vecs[i].mrd;
      tick();
      check1($sformatf("v%0d mvalid", i), a_mvalid, vecs[i].e_mvalid);
      check1($sformatf("v%0d iready", i), a_iready, vecs[i].e_iready);
      check1($sformatf("v%0d dready", i), a_dready, vecs[i].e_dready);
      check1($sformatf("v%0d err", i), a_err, vecs[i].e_err);
      check($sformatf("v%0d idata", i), a_idata, vecs[i].e_idata);
      check($sformatf("v%0d drdata", i), a_drdata, vecs[i].e_drdata);
      if (vecs[i].chk_m) begin
        check($sformatf("v%0d maddr", i), a_maddr, vecs[i].e_maddr);
        check($sformatf("v%0d mwdata", i), a_mwdata, vecs[i].e_mwdata);
        check($sformatf("v%0d mstrb", i), {28'h0, a_mstrb}, {28'h0, vecs[i].e_mstrb});
        check1($sformatf("v%0d mwrite", i), a_mwrite, vecs[i].e_mwrite);
      end
    end

    // Watchdog: load with mready withheld
    begin
      int hi;
      logic seen;
      hi = 0;
      seen = 1'b0;
      idle_inputs();
      dvalid = 1'b1; daddr = 32'h40; dstrb = 4'hf;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (a_mvalid) hi++;
        if (a_dready) begin
          seen = 1'b1;
          check1("tmo err with dready", a_err, 1'b1);
          check("tmo drdata", a_drdata, 32'hFFFF_FFFF);
          check1("tmo mvalid at resp", a_mvalid, 1'b0);
        end
      end
      check1("tmo dready seen", seen, 1'b1);
      check("tmo mvalid cycles", 32'(hi), 32'd4);
      dvalid = 1'b0;
      tick();
      check1("tmo idle dready", a_dready, 1'b0);
      check1("tmo idle err", a_err, 1'b0);
      check1("tmo idle mvalid", a_mvalid, 1'b0);
      check1("no-watchdog still busy", b_mvalid, 1'b1);
    end

    // Reset in the middle of a transaction
    ivalid = 1'b1; iaddr = 32'h200;
    tick();
    check1("pre-rst mvalid", a_mvalid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("async rst mvalid a", a_mvalid, 1'b0);
    check1("async rst mvalid b", b_mvalid, 1'b0);
    iaddr = 32'h300; mready = 1'b1; mrdata = 32'hCAFE;
    tick();
    tick();
    check1("in rst iready", a_iready, 1'b0);
    check1("in rst dready", a_dready, 1'b0);
    reset = 1'b1;
    tick();
    check("post-rst maddr", a_maddr, 32'h300);
    check1("post-rst mvalid", a_mvalid, 1'b1);
    tick();
    check1("post-rst iready a", a_iready, 1'b1);
    check1("post-rst iready b", b_iready, 1'b1);
    check("post-rst idata", a_idata, 32'hCAFE);
    check1("post-rst err", a_err, 1'b0);
    ivalid = 1'b0;
    tick();

    // Simultaneous requests, each held until its own ready
    do_reset();
    ivalid = 1'b1; iaddr = 32'h10;
    dvalid = 1'b1; daddr = 32'h20; dstrb = 4'hf;
    mready = 1'b1; mrdata = 32'h77;
    tick();
    check("pair1 maddr a", a_maddr, 32'h20);
    check("pair1 maddr b", b_maddr, 32'h20);
    tick();
    check1("pair1 dready a", a_dready, 1'b1);
    check1("pair1 dready b", b_dready, 1'b1);
    check1("pair1 iready a", a_iready, 1'b0);
    dvalid = 1'b0;
    tick();
    tick();
    check("pair2 maddr a", a_maddr, 32'h10);
    check("pair2 maddr b", b_maddr, 32'h10);
    tick();
    check1("pair2 iready a", a_iready, 1'b1);
    check1("pair2 iready b", b_iready, 1'b1);
    ivalid = 1'b0;
    tick();

    // Both held continuously: priority always D, round-robin alternates
    ivalid = 1'b1; dvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check1($sformatf("rr%0d busy mvalid a", t), a_mvalid, 1'b1);
      check1($sformatf("rr%0d busy mvalid b", t), b_mvalid, 1'b1);
      tick();
      check1($sformatf("rr%0d dready a", t), a_dready, 1'b1);
      check1($sformatf("rr%0d iready a", t), a_iready, 1'b0);
      check1($sformatf("rr%0d dready b", t), b_dready, (t % 2) == 0);
      check1($sformatf("rr%0d iready b", t), b_iready, (t % 2) == 1);
      check1($sformatf("rr%0d resp mvalid", t), a_mvalid, 1'b0);
      tick();
      check1($sformatf("rr%0d idle mvalid", t), a_mvalid, 1'b0);
      check1($sformatf("rr%0d idle ready", t), a_dready | a_iready, 1'b0);
    end

    // Fetch held with mready held: one transaction every three cycles
    dvalid = 1'b0;
    ivalid = 1'b1; iaddr = 32'h400;
    for (int t = 0; t < 3; t++) begin
      tick();
      check1($sformatf("b2b%0d busy mvalid", t), a_mvalid, 1'b1);
      check1($sformatf("b2b%0d busy iready", t), a_iready, 1'b0);
      tick();
      check1($sformatf("b2b%0d resp iready", t), a_iready, 1'b1);
      check1($sformatf("b2b%0d resp mvalid", t), a_mvalid, 1'b0);
      tick();
      check1($sformatf("b2b%0d idle iready", t), a_iready, 1'b0);
      check1($sformatf("b2b%0d idle mvalid", t), a_mvalid, 1'b0);
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
